load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter BASE_ADDR, default 32'h10010000, byte address of data-memory word 0.
REQ-002 Parameter MEMORY_DEPTH, default 64, number of 32-bit words in data memory; valid byte range is [BASE_ADDR, BASE_ADDR+4*MEMORY_DEPTH-1].
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset; ports SHALL be named clk and reset.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous active-high reset.
REQ-006 req_valid_i  input  1  CPU access request present.
REQ-007 req_ready_o  output  1  block can accept a request.
REQ-008 req_write_i  input  1  1 = store, 0 = load.
REQ-009 req_size_i  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
REQ-010 req_unsigned_i  input  1  zero-extend sub-word loads when 1, sign-extend when 0.
REQ-011 req_addr_i  input  32  byte address.
REQ-012 req_wdata_i  input  32  store data, right-aligned.
REQ-013 resp_valid_o  output  1  response present.
REQ-014 resp_ready_i  input  1  CPU consumes response.
REQ-015 resp_rdata_o  output  32  extended load data; 0 for stores and errors.
REQ-016 resp_error_o  output  1  access rejected.
REQ-017 mem_addr_o  output  32  word-aligned byte address to data memory.
REQ-018 mem_wdata_o  output  32  full word to data memory.
REQ-019 mem_we_o  output  1  data-memory write enable.
REQ-020 mem_rdata_i  input  32  combinational read data for mem_addr_o.

Function
REQ-021 FSM states SHALL be IDLE, ACCESS, RMW_READ, RMW_WRITE, RESP; req_ready_o=1 only in IDLE, resp_valid_o=1 only in RESP.
REQ-022 Handshake: request accepted on a rising edge with req_valid_i=1 and req_ready_o=1; all request fields are captured then and ignored otherwise.
REQ-023 Error conditions: size 11; halfword with addr[0]=1; word with addr[1:0]!=00; address outside the valid range. An erroring request goes IDLE->RESP with resp_error_o=1 and performs no memory access.
REQ-024 Load and word store: IDLE->ACCESS->RESP; resp_valid_o rises 2 cycles after the accepting edge.
REQ-025 Sub-word store: IDLE->RMW_READ->RMW_WRITE->RESP; resp_valid_o rises 3 cycles after the accepting edge.
REQ-026 mem_addr_o SHALL equal {captured_addr[31:2],2'b00} in ACCESS, RMW_READ and RMW_WRITE, and BASE_ADDR otherwise.
REQ-027 mem_we_o SHALL be 1 only in ACCESS for word stores and in RMW_WRITE, and SHALL be decoded from the state register, so it is high for exactly one cycle per store.
REQ-028 Loads: mem_rdata_i is sampled at the end of ACCESS.
REQ-029 Load lane selection is little-endian: byte offset k maps to bits [8k+7:8k]; halfword offset 2 maps to [31:16].
REQ-030 Load extension is from bit 7 (byte) or bit 15 (half) per req_unsigned_i; word loads are unmodified.
REQ-031 RMW_READ: mem_rdata_i is sampled into a merge register.
REQ-032 RMW_WRITE: mem_wdata_o is the merge register with the addressed byte/half lanes replaced by req_wdata_i[7:0] or [15:0]; other lanes are unchanged.
REQ-033 RESP SHALL hold resp_rdata_o and resp_error_o stable until resp_ready_i=1, then return to IDLE on that edge.
REQ-034 A new request is accepted no earlier than the cycle after the RESP exit (one access in flight).
REQ-035 A resp_error_o=1 response SHALL drive resp_rdata_o=0.

Reset
REQ-036 Reset SHALL force IDLE immediately (asynchronously): req_ready_o=1, resp_valid_o=0, resp_error_o=0, resp_rdata_o=0, mem_we_o=0, mem_wdata_o=0, mem_addr_o=BASE_ADDR.
REQ-037 Reset asserted in RMW_READ or RMW_WRITE before the write edge SHALL abort the access without a memory write; the in-flight response is discarded.

Verification
REQ-038 Word at 0x10010004 = 0xAABBCCDD; lb 0x10010007 signed -> resp_rdata_o 0xFFFFFFAA, 2 cycles; lbu -> 0x000000AA.
REQ-039 sh 0x00001234 at 0x10010006 -> one mem_we_o pulse, mem_wdata_o 0x1234CCDD, resp after 3 cycles, resp_error_o=0.
REQ-040 lw 0x10010002, and sw 0x10010100 with depth 64 -> resp_error_o=1, resp_rdata_o=0, mem_we_o never 1, resp after 1 cycle.
REQ-041 resp_ready_i held 0 for 3 cycles after a load -> resp_valid_o and data stable, req_ready_o=0, new req_valid_i ignored.
REQ-042 Reset asserted during RMW_READ of sb -> mem_we_o 0 immediately, memory word unchanged, req_ready_o=1 after release.
REQ-043 sw 0xDEADBEEF to 0x10010008 then lw 0x10010008 back-to-back -> 0xDEADBEEF.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit between a CPU request/response port and a word-wide data memory.
// Sub-word stores use a read-modify-write sequence; misaligned or out-of-range requests answer with an error.
module load_store_unit #(
    parameter logic [31:0] BASE_ADDR    = 32'h10010000,
    parameter int          MEMORY_DEPTH = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_rdata_o,
    output logic        resp_error_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic        mem_we_o,
    input  logic [31:0] mem_rdata_i
);

    typedef enum logic [2:0] {
        IDLE,
        ACCESS,
        RMW_READ,
        RMW_WRITE,
        RESP
    } state_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    // One past the last valid byte; 33 bits so the sum cannot wrap.
    localparam logic [32:0] ADDR_END = {1'b0, BASE_ADDR} + 33'(4 * MEMORY_DEPTH);

    state_t      state;
    state_t      state_next;

    logic        cap_write;
    logic [1:0]  cap_size;
    logic        cap_unsigned;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [31:0] merge_q;
    logic [31:0] rdata_q;
    logic        error_q;

    logic        accept;
    logic        accept_error;
    logic [31:0] word_addr;

    function automatic logic req_error(input logic [1:0] size, input logic [31:0] addr);
        logic bad_align;
        case (size)
            SIZE_BYTE: bad_align = 1'b0;
            SIZE_HALF: bad_align = addr[0];
            SIZE_WORD: bad_align = |addr[1:0];
            default:   bad_align = 1'b1;
        endcase
        return bad_align || ({1'b0, addr} < {1'b0, BASE_ADDR}) || ({1'b0, addr} >= ADDR_END);
    endfunction

    // Little-endian lane pick, then sign or zero extension.
    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                                 input logic [1:0] offset, input logic uns);
        logic [31:0] shifted;
        logic [7:0]  b;
        logic [15:0] h;
        shifted = word >> {offset, 3'b000};
        b = shifted[7:0];
        h = shifted[15:0];
        case (size)
            SIZE_BYTE: return uns ? {24'h0, b} : {{24{b[7]}}, b};
            SIZE_HALF: return uns ? {16'h0, h} : {{16{h[15]}}, h};
            default:   return word;
        endcase
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] wdata,
                                                input logic [1:0] size, input logic [1:0] offset);
        logic [31:0] mask;
        logic [31:0] data;
        if (size == SIZE_BYTE) begin
            mask = 32'h0000_00FF;
            data = {24'h0, wdata[7:0]};
        end else begin
            mask = 32'h0000_FFFF;
            data = {16'h0, wdata[15:0]};
        end
        mask = mask << {offset, 3'b000};
        data = data << {offset, 3'b000};
        return (word & ~mask) | data;
    endfunction

    assign accept       = (state == IDLE) && req_valid_i;
    assign accept_error = req_error(req_size_i, req_addr_i);
    assign word_addr    = {cap_addr[31:2], 2'b00};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Request capture and data path registers; only meaningful while the FSM is busy.
    always_ff @(posedge clk) begin
        if (accept) begin
            cap_write    <= req_write_i;
            cap_size     <= req_size_i;
            cap_unsigned <= req_unsigned_i;
            cap_addr     <= req_addr_i;
            cap_wdata    <= req_wdata_i;
            error_q      <= accept_error;
            rdata_q      <= '0;
        end
        if (state == ACCESS && !cap_write) begin
            rdata_q <= load_extract(mem_rdata_i, cap_size, cap_addr[1:0], cap_unsigned);
        end
        if (state == RMW_READ) begin
            merge_q <= mem_rdata_i;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req_valid_i) begin
                    if (accept_error) begin
                        state_next = RESP;
                    end else if (!req_write_i || req_size_i == SIZE_WORD) begin
                        state_next = ACCESS;
                    end else begin
                        state_next = RMW_READ;
                    end
                end
            end
            ACCESS:    state_next = RESP;
            RMW_READ:  state_next = RMW_WRITE;
            RMW_WRITE: state_next = RESP;
            RESP: begin
                if (resp_ready_i) begin
                    state_next = IDLE;
                end
            end
            default:   state_next = IDLE;
        endcase
    end

    // Every output is decoded from the state register so reset clears them at once.
    always_comb begin
        req_ready_o  = 1'b0;
        resp_valid_o = 1'b0;
        resp_rdata_o = '0;
        resp_error_o = 1'b0;
        mem_addr_o   = BASE_ADDR;
        mem_wdata_o  = '0;
        mem_we_o     = 1'b0;
        case (state)
            IDLE: req_ready_o = 1'b1;
            ACCESS: begin
                mem_addr_o = word_addr;
                if (cap_write) begin
                    mem_we_o    = 1'b1;
                    mem_wdata_o = cap_wdata;
                end
            end
            RMW_READ: mem_addr_o = word_addr;
            RMW_WRITE: begin
                mem_addr_o  = word_addr;
                mem_we_o    = 1'b1;
                mem_wdata_o = store_merge(merge_q, cap_wdata, cap_size, cap_addr[1:0]);
            end
            RESP: begin
                resp_valid_o = 1'b1;
                resp_error_o = error_q;
                resp_rdata_o = error_q ? '0 : rdata_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: table of single accesses plus stall and mid-access reset sequences.
module tb_load_store_unit;

    localparam logic [31:0] BASE = 32'h10010000;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:63];
    logic        init;
    int          we_total = 0;
    int          n_checks = 0;
    int          n_pass   = 0;

    load_store_unit #(.BASE_ADDR(BASE), .MEMORY_DEPTH(64)) dut (
        .clk(clk),
        .reset(reset),
        .req_valid_i(req_valid),
        .req_ready_o(req_ready),
        .req_write_i(req_write),
        .req_size_i(req_size),
        .req_unsigned_i(req_unsigned),
        .req_addr_i(req_addr),
        .req_wdata_i(req_wdata),
        .resp_valid_o(resp_valid),
        .resp_ready_i(resp_ready),
        .resp_rdata_o(resp_rdata),
        .resp_error_o(resp_error),
        .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata),
        .mem_we_o(mem_we),
        .mem_rdata_i(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[7:2]];

    always @(posedge clk) begin
        if (init) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
            mem[1]  <= 32'hAABBCCDD;
            mem[4]  <= 32'h01020304;
            mem[63] <= 32'h80000000;
        end else if (mem_we) begin
            mem[mem_addr[7:2]] <= mem_wdata;
            we_total <= we_total + 1;
        end
    end

    typedef struct {
        logic        write;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          we;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic w, input logic [1:0] s, input logic u,
                                input logic [31:0] a, input logic [31:0] d,
                                input logic [31:0] r, input logic e, input int l, input int we);
        vec_t v;
        v.write = w; v.size = s; v.uns = u; v.addr = a; v.wdata = d;
        v.rdata = r; v.err = e; v.lat = l; v.we = we;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic drive(input logic w, input logic [1:0] s, input logic u,
                         input logic [31:0] a, input logic [31:0] d);
        req_valid = 1'b1; req_write = w; req_size = s; req_unsigned = u;
        req_addr = a; req_wdata = d;
    endtask

    // Drop valid and scramble the fields so only the accepting-edge values matter.
    task automatic scramble();
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'b11; req_unsigned = 1'b0;
        req_addr = 32'hFFFF_FFFF; req_wdata = 32'h0;
    endtask

    task automatic run_vec(input int n, input vec_t v);
        int lat;
        int we0;
        check($sformatf("v%0d ready", n), {31'h0, req_ready}, 32'h1);
        we0 = we_total;
        drive(v.write, v.size, v.uns, v.addr, v.wdata);
        @(posedge clk); #1;
        scramble();
        lat = 1;
        while (!resp_valid && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        check($sformatf("v%0d latency", n), 32'(lat), 32'(v.lat));
        check($sformatf("v%0d rdata", n), resp_rdata, v.rdata);
        check($sformatf("v%0d error", n), {31'h0, resp_error}, {31'h0, v.err});
        check($sformatf("v%0d we_pulses", n), 32'(we_total - we0), 32'(v.we));
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    initial begin
        int we0;
        reset = 1'b1; init = 1'b1; resp_ready = 1'b0;
        scramble();
        repeat (2) @(posedge clk);
        #1;
        check("rst req_ready", {31'h0, req_ready}, 32'h1);
        check("rst resp_valid", {31'h0, resp_valid}, 32'h0);
        check("rst resp_error", {31'h0, resp_error}, 32'h0);
        check("rst resp_rdata", resp_rdata, 32'h0);
        check("rst mem_we", {31'h0, mem_we}, 32'h0);
        check("rst mem_wdata", mem_wdata, 32'h0);
        check("rst mem_addr", mem_addr, BASE);
        init = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;

        //                 w     size   u     addr          wdata         rdata         err   lat we
        vecs.push_back(mk(1'b0, 2'b00, 1'b0, 32'h10010007, 32'h0,        32'hFFFFFFAA, 1'b0, 2, 0));
        vecs.push_back(mk(1'b0, 2'b00, 1'b1, 32'h10010007, 32'h0,        32'h000000AA, 1'b0, 2, 0));
        vecs.push_back(mk(1'b0, 2'b00, 1'b0, 32'h10010004, 32'h0,        32'hFFFFFFDD, 1'b0, 2, 0));
        vecs.push_back(mk(1'b0, 2'b01, 1'b1, 32'h10010004, 32'h0,        32'h0000CCDD, 1'b0, 2, 0));
        vecs.push_back(mk(1'b0, 2'b01, 1'b0, 32'h10010006, 32'h0,        32'hFFFFAABB, 1'b0, 2, 0));
        vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h10010004, 32'h0,        32'hAABBCCDD, 1'b0, 2, 0));
        vecs.push_back(mk(1'b1, 2'b01, 1'b0, 32'h10010006, 32'h00001234, 32'h0,        1'b0, 3, 1));
        vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h10010004, 32'h0,        32'h1234CCDD, 1'b0, 2, 0));
        vecs.push_back(mk(1'b1, 2'b00, 1'b0, 32'h10010005, 32'hFFFFFFEE, 32'h0,        1'b0, 3, 1));
        vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h10010004, 32'h0,        32'h1234EEDD, 1'b0, 2, 0));
        vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h10010002, 32'h0,        32'h0,        1'b1, 1, 0));
        vecs.push_back(mk(1'b1, 2'b10, 1'b0, 32'h10010100, 32'h12345678, 32'h0,        1'b1, 1, 0));
        vecs.push_back(mk(1'b0, 2'b11, 1'b0, 32'h10010004, 32'h0,        32'h0,        1'b1, 1, 0));
        vecs.push_back(mk(1'b0, 2'b00, 1'b0, 32'h1000FFFF, 32'h0,        32'h0,        1'b1, 1, 0));
        vecs.push_back(mk(1'b0, 2'b01, 1'b0, 32'h10010005, 32'h0,        32'h0,        1'b1, 1, 0));
        vecs.push_back(mk(1'b0, 2'b00, 1'b0, 32'h100100FF, 32'h0,        32'hFFFFFF80, 1'b0, 2, 0));
        vecs.push_back(mk(1'b1, 2'b10, 1'b0, 32'h10010008, 32'hDEADBEEF, 32'h0,        1'b0, 2, 1));
        vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h10010008, 32'h0,        32'hDEADBEEF, 1'b0, 2, 0));
        vecs.push_back(mk(1'b1, 2'b01, 1'b0, 32'h10010008, 32'hABCD5555, 32'h0,        1'b0, 3, 1));
        vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h10010008, 32'h0,        32'hDEAD5555, 1'b0, 2, 0));
        vecs.push_back(mk(1'b0, 2'b01, 1'b1, 32'h1001000A, 32'h0,        32'h0000DEAD, 1'b0, 2, 0));
        vecs.push_back(mk(1'b1, 2'b00, 1'b0, 32'h1001000B, 32'h00000077, 32'h0,        1'b0, 3, 1));
        vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h10010008, 32'h0,        32'h77AD5555, 1'b0, 2, 0));

        foreach (vecs[i]) run_vec(i, vecs[i]);

        // Response stall: outputs hold and a competing request is ignored.
        we0 = we_total;
        drive(1'b0, 2'b10, 1'b0, 32'h10010004, 32'h0);
        @(posedge clk); #1;
        scramble();
        @(posedge clk); #1;
        check("stall resp_valid0", {31'h0, resp_valid}, 32'h1);
        drive(1'b1, 2'b10, 1'b0, 32'h1001000C, 32'hCAFEF00D);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check($sformatf("stall%0d resp_valid", i), {31'h0, resp_valid}, 32'h1);
            check($sformatf("stall%0d rdata", i), resp_rdata, 32'h1234EEDD);
            check($sformatf("stall%0d req_ready", i), {31'h0, req_ready}, 32'h0);
        end
        scramble();
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check("stall exit req_ready", {31'h0, req_ready}, 32'h1);
        check("stall exit resp_valid", {31'h0, resp_valid}, 32'h0);
        check("stall no write", 32'(we_total - we0), 32'h0);
        check("stall mem[3]", mem[3], 32'h0);

        // Reset during RMW_READ of a byte store.
        we0 = we_total;
        drive(1'b1, 2'b00, 1'b0, 32'h10010010, 32'h00000099);
        @(posedge clk); #1;
        scramble();
        check("rmwr mem_addr", mem_addr, 32'h10010010);
        reset = 1'b1;
        #1;
        check("rmwr rst mem_we", {31'h0, mem_we}, 32'h0);
        check("rmwr rst req_ready", {31'h0, req_ready}, 32'h1);
        check("rmwr rst mem_addr", mem_addr, BASE);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check("rmwr mem[4]", mem[4], 32'h01020304);
        check("rmwr no write", 32'(we_total - we0), 32'h0);
        check("rmwr req_ready", {31'h0, req_ready}, 32'h1);
        check("rmwr resp_valid", {31'h0, resp_valid}, 32'h0);

        // Reset during RMW_WRITE, before the write edge.
        we0 = we_total;
        drive(1'b1, 2'b00, 1'b0, 32'h10010011, 32'h00000099);
        @(posedge clk); #1;
        scramble();
        @(posedge clk); #1;
        check("rmww mem_we", {31'h0, mem_we}, 32'h1);
        check("rmww mem_wdata", mem_wdata, 32'h01029904);
        reset = 1'b1;
        #1;
        check("rmww rst mem_we", {31'h0, mem_we}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check("rmww mem[4]", mem[4], 32'h01020304);
        check("rmww no write", 32'(we_total - we0), 32'h0);

        run_vec(100, mk(1'b0, 2'b10, 1'b0, 32'h10010010, 32'h0, 32'h01020304, 1'b0, 2, 0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
